// File: rtl/popcount_seq.sv
// Sequenced population counter: captures a TOTAL_W-bit word, then counts it
// CHUNK_W bits per cycle through one shared combinational chunk counter.
module popcount_seq #(
    parameter  int TOTAL_W     = 64,
    parameter  int CHUNK_W     = 10,
    localparam int NCHUNK      = (TOTAL_W + CHUNK_W - 1) / CHUNK_W,
    localparam int CNT_W       = $clog2(TOTAL_W + 1),
    localparam int CHUNK_POS_W = $clog2(CHUNK_W + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [TOTAL_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   out_count,
    output logic               busy
);

    localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PAD_W = NCHUNK * CHUNK_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [TOTAL_W-1:0] word_q, word_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;

    logic [PAD_W-1:0]       word_pad;
    logic [CHUNK_W-1:0]     chunks [NCHUNK];
    logic [CHUNK_W-1:0]     chunk_sel;
    logic [CHUNK_POS_W-1:0] chunk_cnt;
    logic [CNT_W-1:0]       acc_sum;
    logic                   last_chunk;

    // Bits past TOTAL_W in the final chunk are tied to zero rather than sampled.
    genvar gi;
    generate
        for (gi = 0; gi < PAD_W; gi++) begin : g_pad
            if (gi < TOTAL_W) begin : g_bit
                assign word_pad[gi] = word_q[gi];
            end else begin : g_zero
                assign word_pad[gi] = 1'b0;
            end
        end
        for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign chunks[gi] = word_pad[gi*CHUNK_W +: CHUNK_W];
        end
    endgenerate

    always_comb begin
        chunk_sel = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDX_W'(k)) begin
                chunk_sel = chunks[k];
            end
        end
    end

    always_comb begin
        chunk_cnt = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            chunk_cnt = chunk_cnt + CHUNK_POS_W'(chunk_sel[i]);
        end
    end

    assign acc_sum    = acc_q + CNT_W'(chunk_cnt);
    assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        word_d      = word_q;
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;

        if (clear) begin
            state_d     = ST_IDLE;
            idx_d       = '0;
            acc_d       = '0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        word_d     = in_data;
                        idx_d      = '0;
                        acc_d      = '0;
                        state_d    = ST_RUN;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
                    end
                end
                ST_RUN: begin
                    acc_d = acc_sum;
                    idx_d = idx_q + IDX_W'(1);
                    if (last_chunk) begin
                        idx_d       = '0;
                        out_count_d = acc_sum;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Return to IDLE only; the next word is accepted a cycle later.
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                        in_ready_d  = 1'b1;
                        busy_d      = 1'b0;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            word_q      <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            word_q      <= word_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    // clear blocks acceptance in the same cycle, so ready is withdrawn with it.
    assign in_ready  = in_ready_q & ~clear;
    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_popcount_seq.sv
// Directed bench for popcount_seq: scoreboard of expected counts, checked
// with immediate assertions as each result is delivered.
module tb_popcount_seq;

    localparam int TOTAL_W = 64;
    localparam int CNT_W   = 7;
    localparam int NCHUNK  = 7;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               clear = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [TOTAL_W-1:0] in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [CNT_W-1:0]   out_count;
    logic               busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;
    int exp_q[$];

    popcount_seq #(.TOTAL_W(TOTAL_W), .CHUNK_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer a word until accepted; scramble in_data afterwards.
    task automatic send(input logic [TOTAL_W-1:0] d, input bit push);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = {$urandom(), $urandom()};
        if (push) exp_q.push_back($countones(d));
        $display("send  data=%h expected=%0d", d, $countones(d));
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Collect one result; exp_lat > 0 also checks accept-to-valid latency.
    task automatic receive(input int exp_lat);
        int n;
        int exp;
        wait_valid(n);
        chk("out_valid_seen", out_valid, 1);
        if (!out_valid) return;
        if (exp_lat > 0) chk("latency", n, exp_lat);
        chk("in_ready_done", in_ready, 0);
        chk("busy_done", busy, 1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk("count", out_count, exp);
        $display("recv  count=%0d expected=%0d", out_count, exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_after", in_ready, 1);
        chk("out_valid_after", out_valid, 0);
        chk("busy_after", busy, 0);
    endtask

    task automatic watch_no_result(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        logic [TOTAL_W-1:0] w;
        logic [TOTAL_W-1:0] b_word;
        int n;

        // Asynchronous reset asserted mid-cycle.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_count", out_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send(64'hFFFF_FFFF_FFFF_FFFF, 1);
        receive(NCHUNK);
        send(64'h8000_0000_0000_0001, 1);
        receive(NCHUNK);
        send(64'h0, 1);
        receive(NCHUNK);
        w = (64'd1 << 9) | (64'd1 << 10) | (64'd1 << 19) | (64'd1 << 63);
        send(w, 1);
        receive(NCHUNK);
        send(64'h0000_0000_0000_0200, 1);
        receive(NCHUNK);
        for (int i = 0; i < 4; i++) begin
            send({$urandom(), $urandom()}, 1);
            receive(NCHUNK);
        end

        // Backpressure: hold result while a second word is offered.
        send(64'h0123_4567_89AB_CDEF, 1);
        wait_valid(n);
        chk("bp_valid", out_valid, 1);
        b_word = 64'h0000_FFFF_0000_0007;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b_word;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_count_stable", out_count, exp_q[0]);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        receive(0);
        send(b_word, 1);
        receive(NCHUNK);

        // Abort with clear in the third RUN cycle.
        send(64'hFFFF_0000_FFFF_0000, 0);
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        chk("clr_busy", busy, 0);
        chk("clr_in_ready", in_ready, 1);
        chk("clr_out_valid", out_valid, 0);
        watch_no_result("clr_no_result");
        send(64'h00FF_0000_0000_000F, 1);
        receive(NCHUNK);

        // Same abort using an asynchronous reset pulse.
        send(64'hFFFF_0000_FFFF_0000, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rrun_in_ready", in_ready, 1);
        chk("rrun_busy", busy, 0);
        chk("rrun_out_count", out_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_result("rrun_no_result");
        send(64'h00FF_0000_0000_000F, 1);
        receive(NCHUNK);

        // clear beats in_valid in IDLE.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 64'hFFFF;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("clr_idle_not_accepted", busy, 0);

        // clear in DONE discards the pending result even with out_ready.
        send(64'h0F0F, 0);
        wait_valid(n);
        chk("cdone_valid", out_valid, 1);
        clear     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("cdone_out_valid", out_valid, 0);
        chk("cdone_in_ready", in_ready, 1);

        // Async reset while a result is pending.
        send(64'hFFFF_FFFF, 0);
        wait_valid(n);
        chk("rdone_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rdone_out_valid", out_valid, 0);
        chk("rdone_out_count", out_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_result("rdone_no_result");

        send(64'hAAAA_AAAA_AAAA_AAAA, 1);
        receive(NCHUNK);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
